// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Each serial bit is held for CLKS_PER_BIT clocks; outputs are registered from next-state.
module uart_tx_fsm #(
    parameter int WORD_LENGTH  = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] DataIn,
    input  logic                   start,
    output logic                   SerialDataOut,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STARTBIT = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOPBIT  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_LENGTH-1:0] shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   line_q, line_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        bit_end = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (start) begin
                    shreg_d = DataIn;
                    par_d   = ^DataIn;
                    state_d = STARTBIT;
                end
            end
            STARTBIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (PARITY_EN != 0) state_d = PARITY;
                        else                state_d = STOPBIT;
                    end
                end
            end
            PARITY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOPBIT;
                end
            end
            STOPBIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Outputs follow the state being entered so the line changes on the accepting edge.
        line_d = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        case (state_d)
            STARTBIT: line_d = 1'b0;
            DATA:     line_d = shreg_d[0];
            PARITY:   line_d = par_d;
            default:  line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SerialDataOut = line_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: cycle-exact frame checks on a no-parity and a parity instance,
// plus a serial decoder fed from the line with an expected-word scoreboard.
module tb_uart_tx_fsm;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [7:0] din0, din1;
    logic       line0, line1, busy0, busy1, done0, done1;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fsm #(.WORD_LENGTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut0 (
        .clk(clk), .reset(rst_n), .DataIn(din0), .start(start0),
        .SerialDataOut(line0), .busy(busy0), .done(done0)
    );

    uart_tx_fsm #(.WORD_LENGTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut1 (
        .clk(clk), .reset(rst_n), .DataIn(din1), .start(start1),
        .SerialDataOut(line1), .busy(busy1), .done(done1)
    );

    // Expected line for cycle k after the accepting edge (k >= 1).
    function automatic logic exp_line(int k, logic [7:0] w, bit pen);
        int f = (10 + int'(pen)) * C;
        int b;
        if (k > f) return 1'b1;
        b = (k - 1) / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (b == 9 && pen) return ^w;
        return 1'b1;
    endfunction

    function automatic logic exp_busy(int k, bit pen);
        return (k >= 1) && (k <= (10 + int'(pen)) * C + 1);
    endfunction

    function automatic logic exp_done(int k, bit pen);
        return k == (10 + int'(pen)) * C + 1;
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        din0   = 8'h00; din1 = 8'h00;
        repeat (3) @(negedge clk);
        tests++;
        if ({line0, busy0, done0} !== 3'b100) begin
            fails++;
            $display("FAIL reset_dut0: line/busy/done=%b%b%b expected 100", line0, busy0, done0);
        end
        tests++;
        if ({line1, busy1, done1} !== 3'b100) begin
            fails++;
            $display("FAIL reset_dut1: line/busy/done=%b%b%b expected 100", line1, busy1, done1);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({line0, busy0, done0} !== 3'b100) begin
            fails++;
            $display("FAIL idle_after_reset: line/busy/done=%b%b%b expected 100", line0, busy0, done0);
        end
    endtask

    // Full frame compared cycle by cycle; disturb pulses start with new data mid-frame.
    task automatic test_frame(input string name, input logic [7:0] w, input bit pen, input bit disturb);
        logic l, b, d, el, eb, ed;
        @(negedge clk);
        if (pen) begin din1 = w; start1 = 1'b1; end
        else     begin din0 = w; start0 = 1'b1; end
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        for (int k = 1; k <= (10 + int'(pen)) * C + 4; k++) begin
            l  = pen ? line1 : line0;
            b  = pen ? busy1 : busy0;
            d  = pen ? done1 : done0;
            el = exp_line(k, w, pen);
            eb = exp_busy(k, pen);
            ed = exp_done(k, pen);
            tests++;
            if ({l, b, d} !== {el, eb, ed}) begin
                fails++;
                $display("FAIL %s cycle %0d: line/busy/done=%b%b%b expected %b%b%b",
                         name, k, l, b, d, el, eb, ed);
            end
            if (disturb) begin
                start0 = (k == 5) || (k == 100);
                din0   = ~w;
            end
            @(negedge clk);
        end
        start0 = 1'b0;
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        din0 = 8'hC3; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (69) @(negedge clk);
        tests++;
        if (line0 !== 1'b0 || busy0 !== 1'b1) begin
            fails++;
            $display("FAIL mid_frame_bit3: line/busy=%b%b expected 01", line0, busy0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({line0, busy0, done0} !== 3'b100) begin
            fails++;
            $display("FAIL mid_reset: line/busy/done=%b%b%b expected 100", line0, busy0, done0);
        end
        repeat (20) @(negedge clk);
        tests++;
        if ({line0, busy0, done0} !== 3'b100) begin
            fails++;
            $display("FAIL stays_idle_after_reset: line/busy/done=%b%b%b expected 100", line0, busy0, done0);
        end
        test_frame("after_reset_5A", 8'h5A, 1'b0, 1'b0);
    endtask

    // start held: frame 0x00, one idle cycle, then frame 0xFF starting at cycle 163.
    task automatic test_back_to_back();
        logic el, eb, ed;
        int kk;
        logic [7:0] w;
        @(negedge clk);
        din0 = 8'h00; start0 = 1'b1;
        @(negedge clk);
        din0 = 8'hFF;
        for (int k = 1; k <= 162 + 165; k++) begin
            if (k <= 162) begin kk = k;       w = 8'h00; end
            else          begin kk = k - 162; w = 8'hFF; end
            el = exp_line(kk, w, 1'b0);
            eb = exp_busy(kk, 1'b0);
            ed = exp_done(kk, 1'b0);
            tests++;
            if ({line0, busy0, done0} !== {el, eb, ed}) begin
                fails++;
                $display("FAIL back_to_back cycle %0d: line/busy/done=%b%b%b expected %b%b%b",
                         k, line0, busy0, done0, el, eb, ed);
            end
            if (k == 163) start0 = 1'b0;
            @(negedge clk);
        end
        start0 = 1'b0;
    endtask

    // Serial decoder on dut0's line, sampling mid-bit like the RX path.
    task automatic rx_frame(output logic [7:0] data, output bit ok);
        int n;
        ok = 1'b1;
        data = 8'h00;
        n = 0;
        while (line0 !== 1'b0 && n < 8 * C) begin @(negedge clk); n++; end
        if (line0 !== 1'b0) begin ok = 1'b0; return; end
        repeat (C / 2) @(negedge clk);
        if (line0 !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (C) @(negedge clk);
            data[i] = line0;
        end
        repeat (C) @(negedge clk);
        if (line0 !== 1'b1) ok = 1'b0;
        n = 0;
        while (done0 !== 1'b1 && n < 2 * C) begin @(negedge clk); n++; end
        if (done0 !== 1'b1) ok = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [7:0] words[4];
        logic [7:0] got, exp;
        bit ok;
        words = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din0 = words[i]; start0 = 1'b1;
            exp_q.push_back(words[i]);
            @(negedge clk);
            start0 = 1'b0;
            rx_frame(got, ok);
            exp = exp_q.pop_front();
            tests++;
            if (!ok || got !== exp) begin
                fails++;
                $display("FAIL loopback frame %0d: got %h framing_ok=%0d expected %h", i, got, ok, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame("frame_A5", 8'hA5, 1'b0, 1'b0);
        test_frame("parity_07", 8'h07, 1'b1, 1'b0);
        test_frame("parity_03", 8'h03, 1'b1, 1'b0);
        test_frame("start_ignored_96", 8'h96, 1'b0, 1'b1);
        test_mid_reset();
        test_back_to_back();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
